// File: rtl/cnt_pkg.sv
// Shared types and helpers for the run/stop/clear decimal counter.
// The step helper wraps in both directions so the count never leaves 0..9999.
package cnt_pkg;

    typedef enum logic [1:0] {
        STOP,
        RUN,
        CLEAR
    } state_t;

    localparam int unsigned CNT_W = 14;
    localparam logic [CNT_W-1:0] MAX_CNT = 14'd9999;

    function automatic logic [CNT_W-1:0] step_cnt(input logic [CNT_W-1:0] cnt,
                                                  input logic             down);
        if (down) begin
            return (cnt == '0) ? MAX_CNT : cnt - CNT_W'(1);
        end
        return (cnt >= MAX_CNT) ? '0 : cnt + CNT_W'(1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stable-count debouncer and a
// registered one-cycle pulse on each debounced press (releases give no pulse).
module btn_debounce #(
    parameter int unsigned DB_CYCLES = 100_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic level,
    output logic rise_pulse
);

    localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          level_prev_q;
    logic          pulse_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // The counter only runs while the synchronised input disagrees with the level.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            cnt_q        <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            pulse_q      <= 1'b0;
        end else begin
            sync1_q      <= btn_in;
            sync2_q      <= sync1_q;
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_q;
            pulse_q      <= level_q & ~level_prev_q;
        end
    end

    assign level      = level_q;
    assign rise_pulse = pulse_q;

endmodule

// File: rtl/cnt10000_gen.sv
// Run/stop/clear decimal counter feeding the FND display: debounced buttons drive
// a STOP/RUN/CLEAR FSM that gates a prescaled step tick for an up/down 0..9999 count.
module cnt10000_gen
    import cnt_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 10_000_000,
    parameter int unsigned DB_CYCLES = 100_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_run,
    input  logic             btn_clear,
    input  logic             btn_mode,
    output logic [CNT_W-1:0] cnt10000,
    output logic             running,
    output logic             dir_down
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PLAST = PW'(TICK_DIV - 1);

    logic run_p, clear_p, mode_p;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_run (
        .clk        (clk),
        .rst        (rst),
        .btn_in     (btn_run),
        .level      (),
        .rise_pulse (run_p)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clear (
        .clk        (clk),
        .rst        (rst),
        .btn_in     (btn_clear),
        .level      (),
        .rise_pulse (clear_p)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
        .clk        (clk),
        .rst        (rst),
        .btn_in     (btn_mode),
        .level      (),
        .rise_pulse (mode_p)
    );

    state_t           state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             running_q;

    // A step on the same edge as a mode toggle still uses the old direction.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q ^ mode_p;
        case (state_q)
            STOP: begin
                if (clear_p) begin
                    state_d = CLEAR;
                end else if (run_p) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (presc_q == PLAST) begin
                    presc_d = '0;
                    cnt_d   = step_cnt(cnt_q, dir_q);
                end else begin
                    presc_d = presc_q + PW'(1);
                end
                if (run_p) begin
                    state_d = STOP;
                end
            end
            CLEAR: begin
                cnt_d   = '0;
                presc_d = '0;
                state_d = STOP;
            end
            default: state_d = STOP;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= STOP;
            presc_q   <= '0;
            cnt_q     <= '0;
            dir_q     <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            running_q <= (state_d == RUN);
        end
    end

    assign cnt10000 = cnt_q;
    assign running  = running_q;
    assign dir_down = dir_q;

endmodule

// File: tb/tb_cnt10000_gen.sv
// Self-checking bench for cnt10000_gen with a small arithmetic reference model
// (TICK_DIV=10, DB_CYCLES=4); outputs are sampled on the falling clock edge.
module tb_cnt10000_gen;

    localparam int TD  = 10;
    localparam int DB  = 4;
    localparam int EFF = DB + 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_run = 1'b0;
    logic        btn_clear = 1'b0;
    logic        btn_mode = 1'b0;
    logic [13:0] cnt10000;
    logic        running;
    logic        dir_down;

    int n_vec = 0;
    int n_err = 0;
    int n_tog = 0;
    logic run_prev = 1'b0;

    // Reference model state
    int m_cnt, m_presc;
    bit m_run, m_dir, m_clr;

    always #5 clk = ~clk;

    cnt10000_gen #(.TICK_DIV(TD), .DB_CYCLES(DB)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_run   (btn_run),
        .btn_clear (btn_clear),
        .btn_mode  (btn_mode),
        .cnt10000  (cnt10000),
        .running   (running),
        .dir_down  (dir_down)
    );

    always @(negedge clk) begin
        if (running !== run_prev) n_tog++;
        run_prev = running;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: run did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic m_reset();
        m_cnt = 0; m_presc = 0; m_run = 0; m_dir = 0; m_clr = 0;
    endtask

    // One clock edge: a pending clear zeroes everything, RUN advances the tick phase.
    task automatic m_edge();
        if (m_clr) begin
            m_cnt = 0; m_presc = 0; m_clr = 0;
        end else if (m_run) begin
            m_presc++;
            if (m_presc == TD) begin
                m_presc = 0;
                m_cnt = (m_cnt + (m_dir ? 9999 : 1)) % 10000;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        m_edge();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic idle_until(input int want_cnt, input int want_presc);
        int k;
        k = 0;
        while (!((want_cnt < 0 || m_cnt == want_cnt) && m_presc == want_presc) && k < 20000) begin
            cycle();
            k++;
        end
        if (k >= 20000) begin
            n_vec++; n_err++;
            $display("FAIL idle_until: timeout, wanted cnt %0d presc %0d", want_cnt, want_presc);
        end
    endtask

    // mask: [0]=run [1]=clear [2]=mode; bounce 1/0 pairs precede a stable hold.
    task automatic press(input logic [2:0] mask, input int hold, input int bounce);
        int len, eff;
        bit v, pre_run, pre_clr;
        len = 2 * bounce + hold + DB + 6;
        eff = 2 * bounce + EFF;
        for (int j = 1; j <= len; j++) begin
            v = (j <= 2 * bounce) ? (j % 2 == 1) : (j <= 2 * bounce + hold);
            btn_run = mask[0] & v; btn_clear = mask[1] & v; btn_mode = mask[2] & v;
            @(posedge clk);
            pre_run = m_run; pre_clr = m_clr;
            m_edge();
            if (j == eff && hold >= DB) begin
                if (mask[2]) m_dir = !m_dir;
                if (!pre_clr) begin
                    if (pre_run) begin
                        if (mask[0]) m_run = 0;
                    end else if (mask[1]) begin
                        m_clr = 1;
                    end else if (mask[0]) begin
                        m_run = 1;
                    end
                end
            end
            @(negedge clk);
        end
        btn_run = 0; btn_clear = 0; btn_mode = 0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        m_reset();
        repeat (3) @(negedge clk);
        n_vec++;
        if ({cnt10000, running, dir_down} !== 16'h0) begin
            n_err++;
            $display("FAIL reset_hold: got %h required 0", {cnt10000, running, dir_down});
        end
        rst = 1'b1;
        for (int i = 0; i < 100; i++) begin
            cycle();
            n_vec++;
            if ({cnt10000, running, dir_down} !== 16'h0) begin
                n_err++;
                $display("FAIL reset_idle: cyc %0d got %h required 0", i, {cnt10000, running, dir_down});
            end
        end
    endtask

    task automatic test_debounce();
        int tog0;
        press(3'b001, 3, 0);
        n_vec++;
        if (running !== 1'b0) begin
            n_err++;
            $display("FAIL short_glitch: running %b required 0", running);
        end
        for (int j = 1; j <= 10 + DB + 6; j++) begin
            btn_run = (j <= 10);
            @(posedge clk);
            m_edge();
            if (j == EFF) m_run = 1;
            @(negedge clk);
            n_vec++;
            if (running !== 1'(j >= EFF)) begin
                n_err++;
                $display("FAIL run_latency: edge %0d running %b required %b", j, running, j >= EFF);
            end
        end
        btn_run = 0;
        tog0 = n_tog;
        press(3'b001, 6, 2);
        n_vec++;
        if (n_tog - tog0 !== 1 || running !== m_run) begin
            n_err++;
            $display("FAIL bouncy: toggles %0d running %b required 1 and %b",
                     n_tog - tog0, running, m_run);
        end
        n_vec++;
        if (cnt10000 !== 14'(m_cnt)) begin
            n_err++;
            $display("FAIL bouncy_cnt: got %0d required %0d", cnt10000, m_cnt);
        end
    endtask

    task automatic test_wrap();
        press(3'b100, 4, 0);
        if (!m_run) press(3'b001, 4, 0);
        idle_until(9998, 0);
        press(3'b100, 4, 0);
        n_vec++;
        if (cnt10000 !== 14'd9999 || dir_down !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_up_9999: got %0d dir %b required 9999 dir 0", cnt10000, dir_down);
        end
        idle_until(-1, 0);
        n_vec++;
        if (cnt10000 !== 14'd0) begin
            n_err++;
            $display("FAIL wrap_up_0: got %0d required 0", cnt10000);
        end
        press(3'b100, 4, 0);
        n_vec++;
        if (cnt10000 !== 14'd9999 || dir_down !== 1'b1) begin
            n_err++;
            $display("FAIL wrap_down_9999: got %0d dir %b required 9999 dir 1", cnt10000, dir_down);
        end
        idle_until(-1, 0);
        n_vec++;
        if (cnt10000 !== 14'd9998) begin
            n_err++;
            $display("FAIL wrap_down_9998: got %0d required 9998", cnt10000);
        end
    endtask

    task automatic test_pause();
        int c0, exp1;
        // Stop lands EFF edges after the press starts, leaving the phase at 6.
        idle_until(-1, (6 - EFF + 2 * TD) % TD);
        press(3'b001, 4, 0);
        c0 = cnt10000;
        n_vec++;
        if (running !== 1'b0 || cnt10000 !== 14'(m_cnt)) begin
            n_err++;
            $display("FAIL pause_stop: running %b cnt %0d required 0 and %0d", running, cnt10000, m_cnt);
        end
        for (int i = 0; i < 50; i++) begin
            cycle();
            n_vec++;
            if (cnt10000 !== 14'(c0)) begin
                n_err++;
                $display("FAIL pause_frozen: cyc %0d got %0d required %0d", i, cnt10000, c0);
            end
        end
        exp1 = (c0 + (m_dir ? 9999 : 1)) % 10000;
        for (int j = 1; j <= 4 + DB + 6; j++) begin
            btn_run = (j <= 4);
            @(posedge clk);
            m_edge();
            if (j == EFF) m_run = 1;
            @(negedge clk);
            if (j == EFF + 3) begin
                n_vec++;
                if (cnt10000 !== 14'(c0)) begin
                    n_err++;
                    $display("FAIL resume_early: got %0d required %0d", cnt10000, c0);
                end
            end
            if (j == EFF + 4) begin
                n_vec++;
                if (cnt10000 !== 14'(exp1)) begin
                    n_err++;
                    $display("FAIL resume_step: got %0d required %0d", cnt10000, exp1);
                end
            end
        end
        btn_run = 0;
    endtask

    task automatic test_clear();
        int tog0;
        press(3'b100, 4, 0);
        idle_until(123, 0);
        press(3'b010, 4, 0);
        n_vec++;
        if (running !== 1'b1 || cnt10000 !== 14'd124) begin
            n_err++;
            $display("FAIL clear_in_run: running %b cnt %0d required 1 and 124", running, cnt10000);
        end
        press(3'b001, 4, 0);
        press(3'b010, 4, 0);
        n_vec++;
        if (running !== 1'b0 || cnt10000 !== 14'd0) begin
            n_err++;
            $display("FAIL clear_in_stop: running %b cnt %0d required 0 and 0", running, cnt10000);
        end
        press(3'b001, 4, 0);
        idle(25);
        press(3'b001, 4, 0);
        n_vec++;
        if (cnt10000 !== 14'(m_cnt) || m_cnt == 0) begin
            n_err++;
            $display("FAIL pre_combo_cnt: got %0d required %0d (nonzero)", cnt10000, m_cnt);
        end
        tog0 = n_tog;
        press(3'b011, 5, 0);
        n_vec++;
        if (running !== 1'b0 || n_tog !== tog0 || cnt10000 !== 14'd0) begin
            n_err++;
            $display("FAIL run_clear_combo: running %b toggles %0d cnt %0d required 0 0 0",
                     running, n_tog - tog0, cnt10000);
        end
    endtask

    task automatic test_async_reset();
        press(3'b001, 4, 0);
        idle_until(60, 0);
        press(3'b100, 4, 0);
        idle_until(57, 5);
        n_vec++;
        if (cnt10000 !== 14'd57 || running !== 1'b1 || dir_down !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset: cnt %0d run %b dir %b required 57 1 1", cnt10000, running, dir_down);
        end
        #2 rst = 1'b0;
        #1;
        n_vec++;
        if ({cnt10000, running, dir_down} !== 16'h0) begin
            n_err++;
            $display("FAIL async_reset: got %h required 0", {cnt10000, running, dir_down});
        end
        m_reset();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        press(3'b001, 4, 0);
        n_vec++;
        if (running !== 1'b1 || cnt10000 !== 14'(m_cnt)) begin
            n_err++;
            $display("FAIL post_reset_press: running %b cnt %0d required 1 and %0d",
                     running, cnt10000, m_cnt);
        end
    endtask

    task automatic test_random();
        int r;
        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 3);
            case (r)
                0: idle($urandom_range(1, 30));
                1: press(3'b001, $urandom_range(DB, DB + 3), $urandom_range(0, 1));
                2: press(3'b100, $urandom_range(DB, DB + 3), $urandom_range(0, 1));
                default: press(3'b010, $urandom_range(DB, DB + 3), $urandom_range(0, 1));
            endcase
            n_vec++;
            if (cnt10000 !== 14'(m_cnt)) begin
                n_err++;
                $display("FAIL rand_cnt: it %0d got %0d required %0d", it, cnt10000, m_cnt);
            end
            n_vec++;
            if (running !== m_run || dir_down !== m_dir) begin
                n_err++;
                $display("FAIL rand_flags: it %0d run %b dir %b required %b %b",
                         it, running, dir_down, m_run, m_dir);
            end
        end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_wrap();
        test_pause();
        test_clear();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cnt10000_gen.md
# cnt10000_gen

Run/stop/clear decimal counter that produces the 14-bit value 0–9999 shown on the 4-digit FND display, placed directly upstream of the FND controller's `cnt10000` input. Three raw push-buttons are synchronised, debounced and edge-detected. A small FSM gates a prescaled step tick, and the counter steps up or down with decimal wrap-around.

## Interface
- `TICK_DIV`, 10_000_000: clock cycles per count step (10 Hz at 100 MHz); must be ≥ 2.
- `DB_CYCLES`, 100_000: consecutive stable cycles required before a debounced level changes; must be ≥ 1.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `btn_run`  in  1  raw button, asynchronous to `clk`, active-high; press toggles run/stop.
- `btn_clear`  in  1  raw button, active-high; press zeroes the count (STOP only).
- `btn_mode`  in  1  raw button, active-high; press toggles count direction.
- `cnt10000`  out  14  current count, always 0..9999.
- `running`  out  1  1 while FSM in RUN.
- `dir_down`  out  1  0 = count up, 1 = count down.

## Operation
- Reset (rst=0, async): `cnt10000`=0, `running`=0, `dir_down`=0, FSM=STOP, prescaler=0, all debouncers' sync/stable/level/pulse regs = 0.
- Per button, `btn_debounce`: 2-FF synchroniser, then a stable counter. While the synchronised input ≠ debounced level, the counter increments; on the cycle it reaches DB_CYCLES−1, the level takes the new value and the counter clears. Any cycle with input = level clears the counter. A registered rising-edge pulse (level & ~level_d) is one cycle wide. Releases produce no pulse.
- FSM states: STOP, RUN, CLEAR.
  - STOP: clear pulse → CLEAR (priority); else run pulse → RUN.
  - RUN: run pulse → STOP. Clear pulse is ignored.
  - CLEAR: one cycle; on exit `cnt10000`=0, prescaler=0; → STOP unconditionally. Run pulse arriving in CLEAR is lost.
- Prescaler: increments only in RUN; holds its value in STOP, so pause/resume keeps the fractional period. At TICK_DIV−1 it wraps to 0 and a step occurs on the same edge.
- Step: up: 9999→0 else +1; down: 0→9999 else −1. Arithmetic on 14 bits; value never leaves 0..9999.
- Mode pulse toggles `dir_down` in any state, including CLEAR. A step on the same edge uses the old direction.
- Run pulse coinciding with a prescaler wrap in RUN: the step is taken, then the state becomes STOP.

## Timing
- Button latency: raw input high before edge e1 → sync1 at e1, sync2 at e2, level at e(DB_CYCLES+2), pulse at e(DB_CYCLES+3), FSM/`dir_down` update at e(DB_CYCLES+4).
- First step after entering RUN with prescaler=0 occurs exactly TICK_DIV cycles after the state-change edge.
- All outputs are registered, with no combinational path from inputs.
- `running` equals (state==RUN) registered with the state. `cnt10000` changes at most once per TICK_DIV cycles, except for the clear.
- Reset asserted mid-count or mid-debounce returns everything to reset values immediately. The first post-reset press still needs full DB_CYCLES+4 latency.

## Structure
- Package `cnt_pkg`: `state_t` enum {STOP, RUN, CLEAR}, `CNT_W`=14, `MAX_CNT`=14'd9999.
- Sub-module `btn_debounce` (params DB_CYCLES; ports clk, rst, btn_in, level, rise_pulse), instantiated three times.
- Top holds the FSM, prescaler, direction flop and counter.

## Test plan
Bench parameters are TICK_DIV=10 and DB_CYCLES=4 for all scenarios.
- Reset/idle: hold rst=0, then release with buttons low for 100 cycles → `cnt10000`=0, `running`=0, `dir_down`=0 throughout.
- Debounce:
  - Pulse `btn_run` high for 3 cycles → no state change.
  - Hold 10 cycles → `running`=1 exactly DB_CYCLES+4=8 edges after the first sampled high.
  - Bouncy 1-0-1-0 input before a stable hold → exactly one transition.
- Run up with wrap:
  - Force the count to 9998 via a run sequence; → 9999, then 0 on successive 10-cycle ticks.
  - Down mode from 0 → 9999, then 9998.
- Pause/resume:
  - Stop at prescaler=6 → count frozen for 50 cycles.
  - Resume → next step 4 cycles after re-entry to RUN.
- Clear:
  - Clear press in RUN at count 123 → ignored, counting continues.
  - Stop, then clear → `cnt10000`=0 and state STOP.
  - run+clear pulses in the same STOP cycle → CLEAR wins, `running` stays 0.
- Async reset mid-RUN at count 57, prescaler 5 → all outputs 0 in the same cycle as rst falls, with no clk edge needed.
